bus_mux_arbiter_rr4: RTL

//  Round-robin arbiter that shares the 4:1 x 32-bit tri-stated bus mux among

---
 rtl/bus_mux_arbiter_rr4_pkg.sv | 20 ++
 rtl/bus_mux_arbiter_rr4_if.sv | 15 +
 rtl/bus_mux_arbiter_rr4_rr_pick4.sv | 30 +++
 rtl/bus_mux_arbiter_rr4.sv | 117 +++++++++++
 4 files changed

// File: rtl/bus_mux_arbiter_rr4_pkg.sv
// Shared definitions for the round-robin bus-mux arbiter: state encoding,
// requester count and a one-hot to index helper.
package bus_arb_pkg;

    localparam int N_REQ = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN  = 2'd1;
    localparam logic [1:0] TURN = 2'd2;

    function automatic logic [1:0] onehot2idx(input logic [N_REQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_mux_arbiter_rr4_if.sv
// Requester/arbiter handshake plus the mux control lines.
// The master side is the requester group; the slave side is the arbiter.
interface bus_mux_arbiter_rr4_if;
    import bus_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [1:0]       select;
    logic             enable;
    logic             busy;

    modport master (output req, input grant, input select, input enable, input busy);
    modport slave  (input req, output grant, output select, output enable, output busy);

endinterface

// File: rtl/bus_mux_arbiter_rr4_rr_pick4.sv
// Combinational round-robin picker: first masked request after 'last',
// wrapping, with 'last' itself considered last.
module rr_pick4
    import bus_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last,
    input  logic [N_REQ-1:0] mask,
    output logic [1:0]       pick,
    output logic             found
);

    logic [N_REQ-1:0] cand;

    assign cand = req & mask;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && cand[2'(last + 2'(k))]) begin
                pick  = 2'(last + 2'(k));
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_mux_arbiter_rr4.sv
// Round-robin arbiter driving the select/enable of a shared 4:1 tri-state bus
// mux, with a burst limit and an optional idle turnaround between owners.
module bus_mux_arbiter_rr4
    import bus_arb_pkg::*;
#(
    parameter int MAX_BURST  = 8,
    parameter bit TURNAROUND = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bus_mux_arbiter_rr4_if.slave  bus
);

    localparam int             CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       sel_d;
    logic [N_REQ-1:0] grant_d;
    logic             enable_d;
    logic             busy_d;

    logic [N_REQ-1:0] mask;
    logic [1:0]       pick;
    logic             found;
    logic [1:0]       owner;
    logic             release_own;

    assign owner = onehot2idx(bus.grant);

    // A lone owner is never preempted: saturation only matters when someone else waits.
    assign release_own = (state_q == OWN) &&
                         (!bus.req[owner] ||
                          ((cnt_q == CNT_MAX) && |(bus.req & ~bus.grant)));

    // The releasing owner may not win the same edge it lets go on.
    assign mask = (state_q == OWN) ? ~bus.grant : '1;

    rr_pick4 u_pick (
        .req   (bus.req),
        .last  (last_q),
        .mask  (mask),
        .pick  (pick),
        .found (found)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = bus.select;
        case (state_q)
            IDLE, TURN: begin
                if (found) begin
                    state_d = OWN;
                    cnt_d   = CW'(1);
                    last_d  = pick;
                    sel_d   = pick;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (release_own) begin
                    if (TURNAROUND) begin
                        state_d = TURN;
                        cnt_d   = '0;
                    end else if (found) begin
                        cnt_d  = CW'(1);
                        last_d = pick;
                        sel_d  = pick;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        grant_d  = (state_d == OWN) ? (N_REQ'(1) << sel_d) : '0;
        enable_d = (state_d == OWN);
        busy_d   = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values; outputs are registered here so the mux never sees glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 2'd3;
            bus.grant  <= '0;
            bus.select <= '0;
            bus.enable <= 1'b0;
            bus.busy   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            bus.grant  <= grant_d;
            bus.select <= sel_d;
            bus.enable <= enable_d;
            bus.busy   <= busy_d;
        end
    end

endmodule
